// File: rtl/register_dump.sv
// rtl/register_dump.sv - Architectural register dump engine that borrows one PRF src1 read lane.
module register_dump #(
    parameter int NUM_REGS = 34,
    parameter int PHY_LOG  = 7,
    parameter int DATA_W   = 64,
    parameter int ISSUE_W  = 4,
    parameter int RD_LANE  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             startDump_i,
    input  logic [ISSUE_W-1:0][PHY_LOG-1:0]  phySrc1_i,
    input  logic [DATA_W-1:0]                prfRdData_i,
    output logic [ISSUE_W-1:0][PHY_LOG-1:0]  phySrc1_rd_o,
    output logic                             dumpFlag_o,
    output logic                             dumpValid_o,
    input  logic                             dumpReady_i,
    output logic [PHY_LOG-1:0]               dumpAddr_o,
    output logic [DATA_W-1:0]                dumpData_o,
    output logic                             dumpLast_o,
    output logic                             doneDump_o,
    output logic                             busy_o
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_READ,
        ST_CAPTURE,
        ST_SEND,
        ST_FINISH
    } state_t;

    localparam logic [PHY_LOG-1:0] LAST_IDX = PHY_LOG'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [PHY_LOG-1:0]  idx_q, idx_d;
    logic [PHY_LOG-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_beat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Status outputs decode the state register directly so reset clears them without a clock edge.
    assign last_beat = (addr_q == LAST_IDX);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        phySrc1_rd_o = phySrc1_i;
        dumpFlag_o   = 1'b0;
        dumpValid_o  = 1'b0;
        dumpLast_o   = 1'b0;
        doneDump_o   = 1'b0;
        busy_o       = (state_q != ST_WAIT);

        case (state_q)
            ST_WAIT: begin
                if (startDump_i) begin
                    idx_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                phySrc1_rd_o[RD_LANE] = idx_q;
                dumpFlag_o            = 1'b1;
                state_d               = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                dumpFlag_o = 1'b1;
                data_d     = prfRdData_i;
                addr_d     = idx_q;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                dumpValid_o = 1'b1;
                dumpLast_o  = last_beat;
                if (dumpReady_i) begin
                    if (last_beat) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_FINISH: begin
                doneDump_o = 1'b1;
                state_d    = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign dumpAddr_o = addr_q;
    assign dumpData_o = data_q;

endmodule

// File: tb/tb_register_dump.sv
// tb/tb_register_dump.sv - Directed self-checking bench for register_dump.
module tb_register_dump;

    localparam int NUM_REGS = 34;
    localparam int PHY_LOG  = 7;
    localparam int DATA_W   = 64;
    localparam int ISSUE_W  = 4;
    localparam int RD_LANE  = 1;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            startDump_i;
    logic [ISSUE_W-1:0][PHY_LOG-1:0] phySrc1_i;
    logic [DATA_W-1:0]               prfRdData_i = '0;
    logic [ISSUE_W-1:0][PHY_LOG-1:0] phySrc1_rd_o;
    logic                            dumpFlag_o;
    logic                            dumpValid_o;
    logic                            dumpReady_i;
    logic [PHY_LOG-1:0]              dumpAddr_o;
    logic [DATA_W-1:0]               dumpData_o;
    logic                            dumpLast_o;
    logic                            doneDump_o;
    logic                            busy_o;

    logic [DATA_W-1:0] prf [128];
    int tests  = 0;
    int failed = 0;

    register_dump #(
        .NUM_REGS(NUM_REGS), .PHY_LOG(PHY_LOG), .DATA_W(DATA_W),
        .ISSUE_W(ISSUE_W), .RD_LANE(RD_LANE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startDump_i  (startDump_i),
        .phySrc1_i    (phySrc1_i),
        .prfRdData_i  (prfRdData_i),
        .phySrc1_rd_o (phySrc1_rd_o),
        .dumpFlag_o   (dumpFlag_o),
        .dumpValid_o  (dumpValid_o),
        .dumpReady_i  (dumpReady_i),
        .dumpAddr_o   (dumpAddr_o),
        .dumpData_o   (dumpData_o),
        .dumpLast_o   (dumpLast_o),
        .doneDump_o   (doneDump_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // PRF model: one-cycle registered read on the borrowed lane.
    always @(posedge clk) prfRdData_i <= prf[phySrc1_rd_o[RD_LANE]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(dumpValid_o), 64'd0);
        check({tag, "_flag"},  64'(dumpFlag_o),  64'd0);
        check({tag, "_busy"},  64'(busy_o),      64'd0);
        check({tag, "_done"},  64'(doneDump_o),  64'd0);
        check({tag, "_last"},  64'(dumpLast_o),  64'd0);
    endtask

    task automatic run_dump(input int stall_beat, input int stall_len, input bit restart,
                            input int reset_beat, input int exp_done);
        int  n;
        int  beats;
        int  reads;
        int  vcyc;
        int  cur;
        int  stall_cnt;
        bit  finished;
        bit  aborted;
        bit  prev_valid;
        bit  prev_ready;
        bit  prev_flag;
        bit  is_read;
        bit  new_beat;
        logic [PHY_LOG-1:0] h_addr;
        logic [DATA_W-1:0]  h_data;
        logic               h_last;

        n = 0; beats = 0; reads = 0; vcyc = 0; cur = -1; stall_cnt = 0;
        finished = 0; aborted = 0; prev_valid = 0; prev_ready = 1; prev_flag = 0;
        h_addr = '0; h_data = '0; h_last = 1'b0;

        @(negedge clk);
        startDump_i = 1'b1;
        dumpReady_i = 1'b1;
        while (!finished && n < 400) begin
            @(negedge clk);
            n++;
            startDump_i = 1'b0;
            new_beat = 1'b0;
            check("lane0_pass", 64'(phySrc1_rd_o[0]), 64'h12);
            check("lane2_pass", 64'(phySrc1_rd_o[2]), 64'h7f);
            is_read = dumpFlag_o && !prev_flag;
            if (is_read) reads++;
            check("lane1_mux", 64'(phySrc1_rd_o[1]), is_read ? 64'(beats) : 64'h55);
            check("valid_flag_excl", 64'(dumpValid_o & dumpFlag_o), 64'd0);
            if (dumpValid_o) begin
                if (prev_valid && !prev_ready) begin
                    vcyc++;
                    check("hold_addr", 64'(dumpAddr_o), 64'(h_addr));
                    check("hold_data", dumpData_o, h_data);
                    check("hold_last", 64'(dumpLast_o), 64'(h_last));
                end else begin
                    new_beat = 1'b1;
                    cur = beats;
                    vcyc = 1;
                    check("beat_addr", 64'(dumpAddr_o), 64'(cur));
                    check("beat_data", dumpData_o, 64'h1000 + 64'(cur));
                    check("beat_last", 64'(dumpLast_o), 64'(cur == NUM_REGS - 1));
                    h_addr = dumpAddr_o; h_data = dumpData_o; h_last = dumpLast_o;
                    beats++;
                end
                if (cur == stall_beat) stall_cnt = vcyc;
            end
            if (doneDump_o) begin
                finished = 1'b1;
                check("done_cycle", 64'(n), 64'(exp_done));
                check("beat_count", 64'(beats), 64'(NUM_REGS));
                check("read_count", 64'(reads), 64'(NUM_REGS));
                if (restart) startDump_i = 1'b1;
            end else if (new_beat && cur == reset_beat) begin
                reset = 1'b1;
                #1;
                check("arst_valid", 64'(dumpValid_o), 64'd0);
                check("arst_flag",  64'(dumpFlag_o),  64'd0);
                check("arst_busy",  64'(busy_o),      64'd0);
                check("arst_addr",  64'(dumpAddr_o),  64'd0);
                check("arst_data",  dumpData_o,       64'd0);
                check("arst_last",  64'(dumpLast_o),  64'd0);
                check("arst_lane1", 64'(phySrc1_rd_o[1]), 64'h55);
                finished = 1'b1;
                aborted  = 1'b1;
            end else begin
                dumpReady_i = !(dumpValid_o && cur == stall_beat && vcyc <= stall_len);
                if (restart && new_beat && cur == 10) startDump_i = 1'b1;
            end
            prev_valid = dumpValid_o;
            prev_ready = dumpReady_i;
            prev_flag  = dumpFlag_o;
        end
        if (!finished) check("timeout", 64'd0, 64'd1);
        if (stall_beat >= 0 && !aborted) check("stall_valid_cycles", 64'(stall_cnt), 64'(stall_len + 1));
        if (!aborted) begin
            @(negedge clk);
            startDump_i = 1'b0;
            check("done_one_cycle", 64'(doneDump_o), 64'd0);
            check("post_done_busy", 64'(busy_o), 64'd0);
            if (restart) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("no_restart_busy", 64'(busy_o), 64'd0);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) prf[i] = 64'h1000 + 64'(i);
        reset       = 1'b1;
        startDump_i = 1'b0;
        dumpReady_i = 1'b0;
        phySrc1_i[0] = 7'h12;
        phySrc1_i[1] = 7'h55;
        phySrc1_i[2] = 7'h7f;
        phySrc1_i[3] = 7'h33;
        #12;
        check_idle_outputs("reset");
        check("reset_addr", 64'(dumpAddr_o), 64'd0);
        check("reset_data", dumpData_o, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dumpReady_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("idle_after_reset");
        end

        run_dump(-1, 0, 1'b0, -1, 103);
        run_dump(7, 5, 1'b0, -1, 108);
        run_dump(-1, 0, 1'b1, -1, 103);
        run_dump(-1, 0, 1'b0, 20, 0);

        @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle_outputs("abort_no_done");
        end
        run_dump(-1, 0, 1'b0, -1, 103);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
